// File: rtl/dram_cycle_generator_if.sv
// Request/response handshake plus multiplexed DRAM bus between a requester and the
// DRAM cycle generator.
interface dram_cycle_generator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [17:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [8:0]  A;
  logic        RAS_n;
  logic        CASU_n;
  logic        CASL_n;
  logic        WE_n;
  logic        OE_n;
  logic [15:0] D_out;
  logic        D_oe;
  logic [15:0] D_in;

  // Requester side; it also stands in for the board returning read data on D_in.
  modport master (
    output req_valid, req_write, req_addr, req_be, req_wdata, D_in,
    input  req_ready, rsp_valid, rsp_rdata, A, RAS_n, CASU_n, CASL_n, WE_n, OE_n, D_out, D_oe
  );

  // Cycle generator side.
  modport slave (
    input  req_valid, req_write, req_addr, req_be, req_wdata, D_in,
    output req_ready, rsp_valid, rsp_rdata, A, RAS_n, CASU_n, CASL_n, WE_n, OE_n, D_out, D_oe
  );
endinterface

// File: rtl/dram_cycle_generator.sv
// Converts word read/write requests into RAS/CAS strobe sequences on a multiplexed DRAM
// bus and interleaves periodic RAS-only refresh cycles.
module dram_cycle_generator #(
  parameter int unsigned T_RCD            = 2,
  parameter int unsigned T_CAS            = 2,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned REFRESH_INTERVAL = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  dram_cycle_generator_if.slave bus
);

  localparam int unsigned CntW = 8;
  localparam int unsigned TmrW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRow,
    StRas,
    StCol,
    StCas,
    StPre,
    StRefRow,
    StRefRas
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic             pend_q, pend_d;
  logic [8:0]       ref_row_q, ref_row_d;
  logic [17:0]      addr_q, addr_d;
  logic             write_q, write_d;
  logic [1:0]       be_q, be_d;
  logic [15:0]      wdata_q, wdata_d;

  logic [8:0]       a_q, a_d;
  logic             ras_n_q, ras_n_d;
  logic             casu_n_q, casu_n_d;
  logic             casl_n_q, casl_n_d;
  logic             we_n_q, we_n_d;
  logic             oe_n_q, oe_n_d;
  logic [15:0]      d_out_q, d_out_d;
  logic             d_oe_q, d_oe_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic             ref_done;
  logic             expire;
  logic             in_col_cas;

  // ready_q already encodes (idle && !refresh_pending), so it gates acceptance directly.
  assign accept = bus.req_valid && ready_q;
  assign expire = (tmr_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    ref_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          state_d = StRefRow;
        end else if (accept) begin
          state_d = StRow;
        end
      end
      StRow: begin
        state_d = StRas;
        cnt_d   = CntW'(T_RCD - 1);
      end
      StRas: begin
        if (cnt_q == '0) state_d = StCol;
      end
      StCol: begin
        state_d = StCas;
        cnt_d   = CntW'(T_CAS - 1);
      end
      StCas: begin
        if (cnt_q == '0) begin
          state_d = StPre;
          cnt_d   = CntW'(T_RP - 1);
        end
      end
      StPre: begin
        if (cnt_q == '0) state_d = StIdle;
      end
      StRefRow: begin
        state_d = StRefRas;
        cnt_d   = CntW'(T_RCD + T_CAS);
      end
      StRefRas: begin
        if (cnt_q == '0) begin
          state_d  = StPre;
          cnt_d    = CntW'(T_RP - 1);
          ref_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (accept && !pend_q) begin
      addr_d  = bus.req_addr;
      write_d = bus.req_write;
      be_d    = bus.req_be;
      wdata_d = bus.req_wdata;
    end
  end

  // Free-running refresh timer; an expiry while a refresh is still pending is dropped.
  always_comb begin
    tmr_d     = expire ? TmrW'(REFRESH_INTERVAL - 1) : tmr_q - 1'b1;
    pend_d    = (pend_q && !ref_done) || expire;
    ref_row_d = ref_done ? ref_row_q + 9'd1 : ref_row_q;
  end

  // Outputs are decoded from the next state so every pin comes straight from a flop.
  always_comb begin
    in_col_cas = (state_d == StCol) || (state_d == StCas);
    a_d        = a_q;
    unique case (state_d)
      StIdle:             a_d = '0;
      StRow, StRas:       a_d = addr_d[8:0];
      StCol, StCas:       a_d = addr_d[17:9];
      StRefRow, StRefRas: a_d = ref_row_q;
      StPre:              a_d = a_q;
      default:            a_d = '0;
    endcase
    ras_n_d     = !(state_d inside {StRas, StCol, StCas, StRefRas});
    we_n_d      = !(in_col_cas && write_d);
    d_oe_d      = in_col_cas && write_d;
    d_out_d     = ((state_d == StCol) && write_d) ? wdata_d : d_out_q;
    casu_n_d    = !((state_d == StCas) && be_d[1]);
    casl_n_d    = !((state_d == StCas) && be_d[0]);
    oe_n_d      = !((state_d == StCas) && !write_d);
    rsp_valid_d = (state_q == StCas) && (state_d == StPre);
    rdata_d     = ((state_q == StCas) && (cnt_q == '0) && !write_q) ? bus.D_in : rdata_q;
    ready_d     = (state_d == StIdle) && !pend_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tmr_q       <= TmrW'(REFRESH_INTERVAL - 1);
      pend_q      <= 1'b0;
      ref_row_q   <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      a_q         <= '0;
      ras_n_q     <= 1'b1;
      casu_n_q    <= 1'b1;
      casl_n_q    <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      pend_q      <= pend_d;
      ref_row_q   <= ref_row_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      a_q         <= a_d;
      ras_n_q     <= ras_n_d;
      casu_n_q    <= casu_n_d;
      casl_n_q    <= casl_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.A         = a_q;
  assign bus.RAS_n     = ras_n_q;
  assign bus.CASU_n    = casu_n_q;
  assign bus.CASL_n    = casl_n_q;
  assign bus.WE_n      = we_n_q;
  assign bus.OE_n      = oe_n_q;
  assign bus.D_out     = d_out_q;
  assign bus.D_oe      = d_oe_q;

endmodule

// File: tb/tb_dram_cycle_generator.sv
// Scoreboard bench for dram_cycle_generator: one default instance for data cycles and one
// with a 16-clock refresh interval for the refresh sweep.
module tb_dram_cycle_generator;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [15:0] exp_q[$];
  logic [15:0] last_rd;
  logic [15:0] exp_r;

  typedef struct packed {
    logic       ras_n;
    logic       casu_n;
    logic       casl_n;
    logic       we_n;
    logic       oe_n;
    logic       d_oe;
    logic       rsp_valid;
    logic       req_ready;
    logic [8:0] a;
  } view_t;

  dram_cycle_generator_if dbus ();
  dram_cycle_generator_if rbus ();

  dram_cycle_generator u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dbus)
  );

  dram_cycle_generator #(
    .REFRESH_INTERVAL (16)
  ) u_dut_ref (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (rbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pin view for cycle k after acceptance (default timings); coll adds a refresh
  // of row 0 straight after the data cycle.
  function automatic view_t model(int k, logic wr, logic [17:0] addr, logic [1:0] be,
                                  logic coll);
    view_t v;
    v = '{ras_n: 1'b1, casu_n: 1'b1, casl_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, d_oe: 1'b0,
          rsp_valid: 1'b0, req_ready: 1'b0, a: 9'h0};
    case (k)
      1: v.a = addr[8:0];
      2, 3: begin
        v.ras_n = 1'b0;
        v.a     = addr[8:0];
      end
      4: begin
        v.ras_n = 1'b0;
        v.a     = addr[17:9];
        v.we_n  = !wr;
        v.d_oe  = wr;
      end
      5, 6: begin
        v.ras_n  = 1'b0;
        v.a      = addr[17:9];
        v.we_n   = !wr;
        v.d_oe   = wr;
        v.casu_n = !be[1];
        v.casl_n = !be[0];
        v.oe_n   = wr;
      end
      7: begin
        v.a         = addr[17:9];
        v.rsp_valid = 1'b1;
      end
      8: v.a = addr[17:9];
      9: v.req_ready = !coll;
      11, 12, 13, 14, 15: v.ras_n = 1'b0;
      18: v.req_ready = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic view_t observe();
    return '{ras_n: dbus.RAS_n, casu_n: dbus.CASU_n, casl_n: dbus.CASL_n, we_n: dbus.WE_n,
             oe_n: dbus.OE_n, d_oe: dbus.D_oe, rsp_valid: dbus.rsp_valid,
             req_ready: dbus.req_ready, a: dbus.A};
  endfunction

  task automatic do_reset();
    dbus.req_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    last_rd = 16'h0;
  endtask

  // Drives a request and records the rsp_rdata it must produce.
  task automatic issue(input logic wr, input logic [17:0] addr, input logic [1:0] be,
                       input logic [15:0] wdata, input logic [15:0] din);
    dbus.req_write = wr;
    dbus.req_addr  = addr;
    dbus.req_be    = be;
    dbus.req_wdata = wdata;
    dbus.D_in      = din;
    dbus.req_valid = 1'b1;
    if (!wr) last_rd = din;
    exp_q.push_back(last_rd);
  endtask

  task automatic test_reset();
    view_t obs;
    view_t exp;
    dbus.req_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp = '{ras_n: 1'b1, casu_n: 1'b1, casl_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, d_oe: 1'b0,
            rsp_valid: 1'b0, req_ready: 1'b0, a: 9'h0};
    obs = observe();
    obs.req_ready = 1'b0;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_pins: got %h want %h", obs, exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp.req_ready = 1'b1;
    obs = observe();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", obs, exp);
    end
    total++;
    if (dbus.rsp_rdata !== 16'h0 || dbus.D_out !== 16'h0) begin
      bad++;
      $display("FAIL reset_data: got rdata=%h dout=%h want 0", dbus.rsp_rdata, dbus.D_out);
    end
  endtask

  task automatic test_single(input string name, input logic wr, input logic [17:0] addr,
                             input logic [1:0] be, input logic [15:0] wdata,
                             input logic [15:0] din);
    view_t obs;
    view_t exp;
    do_reset();
    total++;
    if (dbus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before: got %b want 1", name, dbus.req_ready);
    end
    issue(wr, addr, be, wdata, din);
    @(posedge clk);
    #1 dbus.req_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      dbus.D_in = (k == 5 || k == 6) ? din : 16'h5A5A;
      obs = observe();
      exp = model(k, wr, addr, be, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", name, k, obs, exp);
      end
      if (exp.d_oe) begin
        total++;
        if (dbus.D_out !== wdata) begin
          bad++;
          $display("FAIL %s dout c%0d: got %h want %h", name, k, dbus.D_out, wdata);
        end
      end
      if (dbus.rsp_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s rsp: got unexpected rsp_valid want none", name);
        end else begin
          exp_r = exp_q.pop_front();
          if (dbus.rsp_rdata !== exp_r) begin
            bad++;
            $display("FAIL %s rdata: got %h want %h", name, dbus.rsp_rdata, exp_r);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending: got %0d outstanding want 0", name, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic        wr_t[5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [17:0] addr_t[5] = '{18'h00000, 18'h3FFFF, 18'h12345, 18'h0ABCD, 18'h3FE00};
    logic [1:0]  be_t[5]   = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [15:0] dat_t[5]  = '{16'h1111, 16'hAAAA, 16'h2222, 16'h5555, 16'h3333};
    int idx;
    int prev;
    do_reset();
    idx  = 0;
    prev = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (dbus.rsp_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b rsp: got unexpected rsp_valid want none");
        end else begin
          exp_r = exp_q.pop_front();
          if (dbus.rsp_rdata !== exp_r) begin
            bad++;
            $display("FAIL b2b rdata: got %h want %h", dbus.rsp_rdata, exp_r);
          end
        end
      end
      if (dbus.req_ready) begin
        if (idx < 5) begin
          total++;
          if (dbus.RAS_n !== 1'b1) begin
            bad++;
            $display("FAIL b2b ras_overlap: got RAS_n=%b want 1 at accept", dbus.RAS_n);
          end
          if (prev >= 0) begin
            total++;
            if (cyc - prev != 9) begin
              bad++;
              $display("FAIL b2b period: got %0d want 9", cyc - prev);
            end
          end
          prev = cyc;
          issue(wr_t[idx], addr_t[idx], be_t[idx], dat_t[idx], dat_t[idx]);
          idx++;
        end else begin
          dbus.req_valid = 1'b0;
        end
      end
    end
    dbus.req_valid = 1'b0;
    total++;
    if (idx != 5 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b done: got issued=%0d outstanding=%0d want 5 and 0", idx, exp_q.size());
    end
  endtask

  task automatic test_collision();
    view_t obs;
    view_t exp;
    do_reset();
    repeat (63) @(posedge clk);
    @(negedge clk);
    issue(1'b0, 18'h0A0A5, 2'b11, 16'h0, 16'hC0DE);
    @(posedge clk);
    #1 dbus.req_valid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      obs = observe();
      exp = model(k, 1'b0, 18'h0A0A5, 2'b11, 1'b1);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL collision cycle %0d: got %h want %h", k, obs, exp);
      end
      if (dbus.rsp_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL collision rsp: got unexpected rsp_valid want none");
        end else begin
          exp_r = exp_q.pop_front();
          if (dbus.rsp_rdata !== exp_r) begin
            bad++;
            $display("FAIL collision rdata: got %h want %h", dbus.rsp_rdata, exp_r);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_cas();
    view_t obs;
    view_t exp;
    logic  got;
    logic  seen;
    do_reset();
    issue(1'b0, 18'h0F00F, 2'b11, 16'h0, 16'h7777);
    @(posedge clk);
    #1 dbus.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dbus.rsp_valid && !got) begin
        got = 1'b1;
        exp_r = exp_q.pop_front();
        total++;
        if (dbus.rsp_rdata !== exp_r) begin
          bad++;
          $display("FAIL abort pre_read: got %h want %h", dbus.rsp_rdata, exp_r);
        end
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL abort pre_read timeout: got no rsp_valid want one");
    end
    issue(1'b0, 18'h155AA, 2'b11, 16'h0, 16'h9999);
    @(posedge clk);
    #1 dbus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (dbus.CASL_n !== 1'b0) begin
      bad++;
      $display("FAIL abort in_cas: got CASL_n=%b want 0", dbus.CASL_n);
    end
    reset_n = 1'b0;
    #1;
    exp = '{ras_n: 1'b1, casu_n: 1'b1, casl_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, d_oe: 1'b0,
            rsp_valid: 1'b0, req_ready: 1'b0, a: 9'h0};
    obs = observe();
    obs.req_ready = 1'b0;
    total++;
    if (obs !== exp || dbus.rsp_rdata !== 16'h0) begin
      bad++;
      $display("FAIL abort pins: got %h rdata=%h want %h rdata=0", obs, dbus.rsp_rdata, exp);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dbus.rsp_valid) seen = 1'b1;
    end
    reset_n = 1'b1;
    exp_q.delete();
    last_rd = 16'h0;
    @(negedge clk);
    if (dbus.rsp_valid) seen = 1'b1;
    total++;
    if (seen !== 1'b0 || dbus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort release: got rsp_seen=%b ready=%b want 0 and 1", seen,
               dbus.req_ready);
    end
    issue(1'b0, 18'h00200, 2'b01, 16'h0, 16'h4321);
    @(posedge clk);
    #1 dbus.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dbus.rsp_valid && !got) begin
        got = 1'b1;
        exp_r = exp_q.pop_front();
        total++;
        if (dbus.rsp_rdata !== exp_r) begin
          bad++;
          $display("FAIL abort post_read: got %h want %h", dbus.rsp_rdata, exp_r);
        end
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL abort post_read timeout: got no rsp_valid want one");
    end
  endtask

  task automatic test_refresh();
    logic prev_ras;
    logic quiet_bad;
    int   n;
    int   last;
    logic [8:0] exp_row;
    do_reset();
    prev_ras  = 1'b1;
    quiet_bad = 1'b0;
    n         = 0;
    last      = 0;
    for (int cyc = 0; cyc < 513 * 16 + 48; cyc++) begin
      @(negedge clk);
      if (!rbus.CASU_n || !rbus.CASL_n || !rbus.WE_n || !rbus.OE_n || rbus.rsp_valid ||
          rbus.D_oe) begin
        quiet_bad = 1'b1;
      end
      if (prev_ras && !rbus.RAS_n) begin
        exp_row = 9'(n % 512);
        total++;
        if (rbus.A !== exp_row) begin
          bad++;
          $display("FAIL refresh row %0d: got %h want %h", n, rbus.A, exp_row);
        end
        if (n > 0) begin
          total++;
          if (cyc - last != 16) begin
            bad++;
            $display("FAIL refresh period %0d: got %0d want 16", n, cyc - last);
          end
        end
        last = cyc;
        n++;
      end
      prev_ras = rbus.RAS_n;
    end
    total++;
    if (quiet_bad !== 1'b0 || n < 513) begin
      bad++;
      $display("FAIL refresh quiet: got cas_activity=%b count=%0d want 0 and >=513",
               quiet_bad, n);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    last_rd        = 16'h0;
    reset_n        = 1'b1;
    dbus.req_valid = 1'b0;
    dbus.req_write = 1'b0;
    dbus.req_addr  = '0;
    dbus.req_be    = '0;
    dbus.req_wdata = '0;
    dbus.D_in      = '0;
    rbus.req_valid = 1'b0;
    rbus.req_write = 1'b0;
    rbus.req_addr  = '0;
    rbus.req_be    = '0;
    rbus.req_wdata = '0;
    rbus.D_in      = '0;
    test_reset();
    test_single("read", 1'b0, 18'h2A5F3, 2'b11, 16'h0000, 16'hBEEF);
    test_single("write", 1'b1, 18'h00001, 2'b10, 16'h1234, 16'h0000);
    test_single("read_be0", 1'b0, 18'h3FFFF, 2'b00, 16'h0000, 16'h0F0F);
    test_back_to_back();
    test_collision();
    test_reset_mid_cas();
    test_refresh();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
